// File: rtl/input_port_rx_if.sv
// Link-side and core-side signals of one router input port.
// The upstream router and router core use master; the receiver uses slave.
interface input_port_rx_if;
  logic [31:0] data_in;
  logic        write_in_signal;
  logic        ack_out;
  logic [2:0]  capacity_out;
  logic [31:0] data_out;
  logic        ready_out;
  logic        next_in;

  modport master (
    output data_in, write_in_signal, next_in,
    input  ack_out, capacity_out, data_out, ready_out
  );

  modport slave (
    input  data_in, write_in_signal, next_in,
    output ack_out, capacity_out, data_out, ready_out
  );
endinterface

// File: rtl/input_port_rx.sv
// Router input port receiver: stores flits speculatively, validates each packet,
// answers with a one-cycle ack/nack and commits only accepted packets for the core.
module input_port_rx #(
  parameter int DEPTH   = 7,
  parameter int TIMEOUT = 8
) (
  input  logic           clock,
  input  logic           reset,
  input_port_rx_if.slave port
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RECV, RESP} state_t;

  state_t           state;
  logic [31:0]      mem [DEPTH];
  logic [2:0]       wr_ptr;
  logic [2:0]       cm_ptr;
  logic [2:0]       rd_ptr;
  logic [2:0]       spec_cnt;
  logic [2:0]       com_cnt;
  logic [2:0]       remaining;
  logic [GAP_W-1:0] gap;
  logic             err;
  logic             ack_r;
  logic [2:0]       cap_r;

  logic             ready;
  logic             pop;
  logic [2:0]       size_in;
  logic             parity_ok;
  logic             hdr_zero;
  logic             store;
  logic             full;
  logic             do_write;
  logic             flit_err;

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == 3'(DEPTH - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [2:0] sat_cap(input logic [2:0] used);
    int free;
    free = DEPTH - int'(used);
    if (free > 7) return 3'd7;
    return 3'(free);
  endfunction

  assign ready = (com_cnt != 3'd0);

  always_comb begin
    pop       = port.next_in && ready;
    size_in   = port.data_in[24:22];
    parity_ok = ~(^port.data_in);
    hdr_zero  = (size_in == 3'd0);
    store     = port.write_in_signal &&
                (((state == IDLE) && !hdr_zero) || (state == RECV));
    // A same-cycle pop frees an entry before the write needs it.
    full      = (spec_cnt == 3'(DEPTH)) && !pop;
    do_write  = store && !full;
    flit_err  = store && (full || !parity_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= 3'd0;
      cm_ptr    <= 3'd0;
      rd_ptr    <= 3'd0;
      spec_cnt  <= 3'd0;
      com_cnt   <= 3'd0;
      remaining <= 3'd0;
      gap       <= '0;
      err       <= 1'b0;
      ack_r     <= 1'b0;
      cap_r     <= sat_cap(3'd0);
    end else begin
      ack_r    <= 1'b0;
      cap_r    <= sat_cap(spec_cnt);
      spec_cnt <= spec_cnt + {2'b00, do_write} - {2'b00, pop};
      com_cnt  <= com_cnt - {2'b00, pop};
      if (pop)      rd_ptr <= ptr_inc(rd_ptr);
      if (do_write) wr_ptr <= ptr_inc(wr_ptr);

      case (state)
        IDLE: begin
          if (port.write_in_signal) begin
            remaining <= size_in - 3'd1;
            gap       <= '0;
            err       <= hdr_zero || flit_err;
            if (size_in <= 3'd1) begin
              state <= RESP;
              ack_r <= !(hdr_zero || flit_err);
            end else begin
              state <= RECV;
            end
          end
        end
        RECV: begin
          if (port.write_in_signal) begin
            remaining <= remaining - 3'd1;
            gap       <= '0;
            err       <= err || flit_err;
            if (remaining == 3'd1) begin
              state <= RESP;
              ack_r <= !(err || flit_err);
            end
          end else if (gap == GAP_W'(TIMEOUT - 1)) begin
            // Stalled transmitter: discard the partial packet silently.
            wr_ptr   <= cm_ptr;
            spec_cnt <= com_cnt - {2'b00, pop};
            gap      <= '0;
            state    <= IDLE;
          end else begin
            gap <= gap + GAP_W'(1);
          end
        end
        RESP: begin
          if (err) begin
            wr_ptr   <= cm_ptr;
            spec_cnt <= com_cnt - {2'b00, pop};
          end else begin
            cm_ptr  <= wr_ptr;
            com_cnt <= spec_cnt - {2'b00, pop};
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_write) mem[wr_ptr] <= port.data_in;
  end

  assign port.ack_out      = ack_r;
  assign port.capacity_out = cap_r;
  assign port.ready_out    = ready;
  assign port.data_out     = ready ? mem[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_input_port_rx.sv
// Scoreboard bench for input_port_rx: accepted packets are queued at their ack
// and compared flit by flit as the core side pops them.
module tb_input_port_rx;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  input_port_rx_if vif ();

  input_port_rx #(.DEPTH(7), .TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .port  (vif)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ack_seen = 0;
  int          exp_acks = 0;
  logic [31:0] sb [$];
  logic [31:0] pkt [8];
  int          pkt_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] mk_flit(input logic [31:0] raw);
    logic [31:0] f;
    f     = raw;
    f[31] = ^raw[30:0];
    return f;
  endfunction

  task automatic build_pkt(input int n, input logic [2:0] size, input int bad);
    logic [31:0] raw;
    pkt_len = n;
    raw = {2'b00, 5'($urandom_range(0, 4)), size, 22'($urandom)};
    pkt[0] = mk_flit(raw);
    for (int i = 1; i < n; i++) pkt[i] = mk_flit($urandom);
    if (bad >= 0) pkt[bad][31] = ~pkt[bad][31];
  endtask

  task automatic drive_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      vif.data_in         = pkt[i];
      vif.write_in_signal = 1'b1;
      tick();
    end
    vif.write_in_signal = 1'b0;
    vif.data_in         = 32'd0;
  endtask

  // Called in the response cycle; leaves the bench in the following cycle.
  task automatic finish_resp(input logic exp_ack, input string tag);
    check(tag, {31'd0, vif.ack_out}, {31'd0, exp_ack});
    if (exp_ack) begin
      exp_acks++;
      for (int i = 0; i < pkt_len; i++) sb.push_back(pkt[i]);
    end
    tick();
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    vif.next_in = 1'b1;
    while (sb.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    vif.next_in = 1'b0;
    settle(2);
    check({tag, "_ready_idle"}, {31'd0, vif.ready_out}, 32'd0);
    check({tag, "_cap_full"}, {29'd0, vif.capacity_out}, 32'd7);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   {31'd0, vif.ack_out},      32'd0);
    check({tag, "_ready"}, {31'd0, vif.ready_out},    32'd0);
    check({tag, "_data"},  vif.data_out,              32'd0);
    check({tag, "_cap"},   {29'd0, vif.capacity_out}, 32'd7);
  endtask

  always @(negedge clock) begin
    if (!reset && vif.next_in && vif.ready_out) begin
      logic [31:0] exp;
      exp = (sb.size() != 0) ? sb.pop_front() : 32'bx;
      check("pop_data", vif.data_out, exp);
    end
  end

  always @(negedge clock) begin
    if (vif.ack_out === 1'b1) ack_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vif.data_in         = 32'd0;
    vif.write_in_signal = 1'b0;
    vif.next_in         = 1'b0;
    settle(2);
    reset = 1'b0;
    check_reset_outputs("rst0");

    // Good 3-flit packet
    build_pkt(3, 3'd3, -1);
    drive_range(0, 3);
    check("t1_ready_in_resp", {31'd0, vif.ready_out}, 32'd0);
    finish_resp(1'b1, "t1_ack");
    check("t1_ready_rise", {31'd0, vif.ready_out}, 32'd1);
    check("t1_cap", {29'd0, vif.capacity_out}, 32'd4);
    check("t1_head", vif.data_out, pkt[0]);
    drain("t1");

    // Parity error on flit 2, then clean retransmit
    build_pkt(4, 3'd4, 1);
    drive_range(0, 4);
    finish_resp(1'b0, "t2_nack");
    check("t2_ready_stays", {31'd0, vif.ready_out}, 32'd0);
    tick();
    check("t2_cap_restored", {29'd0, vif.capacity_out}, 32'd7);
    build_pkt(4, 3'd4, -1);
    drive_range(0, 4);
    finish_resp(1'b1, "t2_retx_ack");
    drain("t2");

    // Overflow: 5 committed, then 3 more do not fit
    build_pkt(5, 3'd5, -1);
    drive_range(0, 5);
    finish_resp(1'b1, "t3_ack5");
    build_pkt(3, 3'd3, -1);
    drive_range(0, 3);
    finish_resp(1'b0, "t3_nack_ovf");
    tick();
    check("t3_cap_after_rollback", {29'd0, vif.capacity_out}, 32'd2);
    drain("t3");

    // Timeout after 4 idle cycles, then a 3-idle gap that must survive
    build_pkt(4, 3'd4, -1);
    drive_range(0, 2);
    for (int i = 0; i < 4; i++) begin
      check("t4_no_ack", {31'd0, vif.ack_out}, 32'd0);
      tick();
    end
    tick();
    check("t4_cap_restored", {29'd0, vif.capacity_out}, 32'd7);
    check("t4_ready", {31'd0, vif.ready_out}, 32'd0);
    build_pkt(3, 3'd3, -1);
    drive_range(0, 2);
    settle(3);
    drive_range(2, 3);
    finish_resp(1'b1, "t4_gap3_ack");
    drain("t4");

    // Back-to-back packets with continuous pops; pointers wrap
    vif.next_in = 1'b1;
    for (int p = 0; p < 20; p++) begin
      build_pkt(2, 3'd2, -1);
      drive_range(0, 2);
      finish_resp(1'b1, "t5_ack");
    end
    build_pkt(1, 3'd1, -1);
    drive_range(0, 1);
    finish_resp(1'b1, "t5_size1_ack");
    build_pkt(1, 3'd0, -1);
    drive_range(0, 1);
    finish_resp(1'b0, "t5_size0_nack");
    drain("t5");

    // Reset in the middle of a packet
    build_pkt(5, 3'd5, -1);
    drive_range(0, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("t6_rst");
    build_pkt(3, 3'd3, -1);
    drive_range(0, 3);
    finish_resp(1'b1, "t6_ack");
    drain("t6");

    settle(2);
    check("ack_pulses", 32'(ack_seen), 32'(exp_acks));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/input_port_rx.md
Name: input_port_rx

Overview:
Receiving end of the router-to-router link. It accepts flits that the upstream router drives with write_signal. It stores them speculatively, validates each packet, and returns a single-cycle ack/nack in a fixed response slot. Only accepted packets are committed and exposed to the router core through a ready/next pop interface. One instance sits on each of the 5 router input ports and replaces the bare per-port buffer.

Parameters:
DEPTH, 7, flit storage entries (2..7); capacity_out saturates at 7
TIMEOUT, 8, max consecutive idle cycles allowed inside a packet before abort (>=1)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
data_in  in  32  flit from upstream router
write_in_signal  in  1  flit on data_in valid this cycle
ack_out  out  1  response to upstream: 1=accept, 0=nack (meaningful only in the response cycle)
capacity_out  out  3  free flit entries (speculative), registered, saturated at 7
data_out  out  32  head flit of committed storage; 0 when ready_out=0
ready_out  out  1  at least one committed flit available
next_in  in  1  pop head flit (router core side)

Behaviour:
- Flit format:
  - header flit: [29:25] destination id, [24:22] packet size in flits including header (1..7).
  - every flit: bit 31 is even parity, so the XOR of all 32 bits must be 0.
- Storage:
  - circular array of DEPTH entries, with pointers wrapping modulo DEPTH.
  - wr_ptr (speculative), cm_ptr (commit), rd_ptr (read).
  - counters spec_cnt = entries between rd_ptr and wr_ptr; com_cnt = entries between rd_ptr and cm_ptr.
- capacity_out = min(7, DEPTH - spec_cnt), registered, updated every cycle.
- ready_out = (com_cnt != 0). data_out = mem[rd_ptr] when ready_out, else 0. Read path is combinational.
- Pop: next_in with ready_out=1 advances rd_ptr and decrements both counters. next_in with ready_out=0 is ignored.
- A pop and a write in the same cycle are both performed; the net counter change is applied.
- FSM states: IDLE, RECV, RESP.
- IDLE:
  - write_in_signal=1 means the flit is a header. Clear err, load remaining = size-1, clear gap counter.
  - header with size==0: set err, store nothing, go to RESP.
  - otherwise store the flit (rules below). If size==1 go to RESP, else go to RECV.
- RECV:
  - write_in_signal=1: store the flit, decrement remaining, clear gap counter. When remaining reaches 0, go to RESP.
  - write_in_signal=0: increment gap counter. When gap == TIMEOUT, roll back (wr_ptr<=cm_ptr, spec_cnt<=com_cnt), go to IDLE, emit no ack pulse.
- Store rule:
  - if spec_cnt==DEPTH (after a same-cycle pop is accounted for), do not write; set err (overflow).
  - parity failure: the flit is written but err is set.
  - every flit of the packet is consumed in both cases.
- RESP (exactly one cycle, the cycle after the last flit was sampled):
  - ack_out=1 iff err=0. Then cm_ptr<=wr_ptr and com_cnt<=spec_cnt; the new packet is visible as ready_out the next cycle.
  - if err=1: ack_out=0 and roll back wr_ptr/spec_cnt to the commit values.
  - always return to IDLE.
- write_in_signal during RESP is ignored, because the transmitter must wait for the response.
- ack_out is 0 in every cycle other than an accepting RESP.
- Latency:
  - last flit at cycle N, ack at N+1.
  - head flit of the packet is poppable at N+2 if it is the oldest committed data.
  - capacity reflects a stored flit one cycle later.
- Reset (any state, including mid-packet):
  - outputs: ack_out=0, ready_out=0, data_out=0, capacity_out=min(7,DEPTH).
  - internal: all pointers and counters 0, FSM in IDLE, err=0.
  - the partially received packet is dropped with no ack.

Test Plan:
1. Good packet, DEPTH=7: 3 good-parity flits on consecutive cycles (header size=3) -> ack_out=1 exactly one cycle after flit 3. capacity_out goes 7->4. ready_out rises the next cycle. Three next_in pops return the flits in order. capacity_out returns to 7.
2. Parity error: 4-flit packet with bit 31 flipped on flit 2 -> ack_out=0 in the response slot. ready_out stays 0 and capacity_out returns to 7. An immediate clean retransmit is acked with ack_out=1.
3. Overflow: commit a 5-flit packet (no pops), then send a 3-flit packet -> nack. The 5 committed flits are intact and pop out unchanged. capacity_out=2 after rollback.
4. Timeout, TIMEOUT=4: header size=4 plus 1 flit, then write_in_signal low for 4 cycles -> FSM returns to IDLE with no ack pulse. capacity_out is restored. The next header is accepted normally.
5. Wrap with concurrent pops: 20 back-to-back 2-flit packets while next_in is held high -> every packet acked. Pointers wrap modulo 7 and output order is preserved. Simultaneous pop and write keep the counters exact.
6. Reset mid-packet: assert reset after flit 2 of a 5-flit packet -> next cycle all outputs are at reset values. The following clean packet is acked and is the only data popped.
